// File: rtl/pulse_burst_gen.sv
// -----------------------------------------------------------------------------
// pulse_burst_gen
//
// Emits a burst of N identical pulses on request. Each pulse is HIGH_CYC
// clocks high followed by LOW_CYC clocks low. N is sampled from count_i on
// the start_i cycle. A one-cycle done_o strobe marks normal completion.
// An abort or a reset ends the burst without a done_o strobe.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
//
// Parameters
//   CNT_W     width of count_i / remaining_o
//   HIGH_CYC  clocks pulse_o is high per pulse (1..255)
//   LOW_CYC   clocks pulse_o is low after each pulse (1..255)
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   start_i      single-cycle burst request (accepted only when idle)
//   count_i      number of pulses in the burst, sampled with start_i
//   abort_i      terminate an in-progress burst (ignored when idle)
//   pulse_o      registered pulse train
//   busy_o       high while a burst is in progress
//   done_o       one-cycle completion strobe
//   remaining_o  pulses of the burst not yet started
// -----------------------------------------------------------------------------
module pulse_burst_gen #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned HIGH_CYC = 1,
    parameter int unsigned LOW_CYC  = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             abort_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] remaining_o
);

    // The phase counter only has to reach the longer phase's last index.
    localparam int unsigned PH_MAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_CYC - 1);
    localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  rem_q,   rem_d;
    logic              pulse_q, pulse_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                phase_d = '0;
                rem_d   = '0;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                // abort_i has no meaning here, so start always proceeds.
                if (start_i) begin
                    if (count_i != '0) begin
                        state_d = S_HIGH;
                        rem_d   = count_i - CNT_W'(1);
                        pulse_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        // Empty burst: completes immediately, no pulse.
                        done_d = 1'b1;
                    end
                end
            end

            S_HIGH: begin
                if (phase_q == HIGH_LAST) begin
                    state_d = S_LOW;
                    phase_d = '0;
                    pulse_d = 1'b0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            S_LOW: begin
                if (phase_q == LOW_LAST) begin
                    phase_d = '0;
                    if (rem_q != '0) begin
                        // Next pulse starts; its count is consumed as it rises.
                        state_d = S_HIGH;
                        rem_d   = rem_q - CNT_W'(1);
                        pulse_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                rem_d   = '0;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything above while busy; start_i is dropped and
        // no done strobe is produced.
        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
            phase_d = '0;
            rem_d   = '0;
            pulse_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            rem_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pulse_o     = pulse_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign remaining_o = rem_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_burst_gen
//
// Two instances: A with default timing, B with HIGH_CYC=3 / LOW_CYC=2.
// When a burst is accepted, the bench pushes the full expected per-cycle
// output timeline onto that instance's queue; each cycle one entry is popped
// and compared (an empty queue means the idle pattern is expected).
// -----------------------------------------------------------------------------
module tb_pulse_burst_gen;

    typedef struct packed {
        logic       pulse;
        logic       busy;
        logic       done;
        logic [3:0] rem;
    } exp_t;

    localparam int unsigned HA = 1, LA = 1;
    localparam int unsigned HB = 3, LB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, abort_a, start_b, abort_b;
    logic [3:0] cnt_a, cnt_b;
    logic       pulse_a, busy_a, done_a, pulse_b, busy_b, done_b;
    logic [3:0] rem_a, rem_b;

    always #5 clk = ~clk;

    pulse_burst_gen #(.CNT_W(4), .HIGH_CYC(HA), .LOW_CYC(LA)) dut_a (
        .clk_i(clk), .reset_i(rst), .start_i(start_a), .count_i(cnt_a),
        .abort_i(abort_a), .pulse_o(pulse_a), .busy_o(busy_a),
        .done_o(done_a), .remaining_o(rem_a)
    );

    pulse_burst_gen #(.CNT_W(4), .HIGH_CYC(HB), .LOW_CYC(LB)) dut_b (
        .clk_i(clk), .reset_i(rst), .start_i(start_b), .count_i(cnt_b),
        .abort_i(abort_b), .pulse_o(pulse_b), .busy_o(busy_b),
        .done_o(done_b), .remaining_o(rem_b)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t last_a = '0, last_b = '0;
    logic prev_pa = 1'b0, prev_pb = 1'b0;
    int   npulse_a = 0;
    logic [3:0] npulse_b = '0;   // downstream 4-bit pulse counter

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic clear_q(input int d);
        if (d == 0) qa.delete();
        else        qb.delete();
    endtask

    // Expected timeline of an accepted burst, one entry per cycle after start.
    task automatic launch(input int d, input int n, input int h, input int l);
        exp_t e;
        clear_q(d);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < h; c++) begin
                e = '{pulse: 1'b1, busy: 1'b1, done: 1'b0, rem: 4'(n - 1 - k)};
                push(d, e);
            end
            for (int c = 0; c < l; c++) begin
                e = '{pulse: 1'b0, busy: 1'b1, done: 1'b0, rem: 4'(n - 1 - k)};
                push(d, e);
            end
        end
        e = '{pulse: 1'b0, busy: 1'b0, done: 1'b1, rem: 4'd0};
        push(d, e);
    endtask

    // Applies the inputs about to be sampled to the expectation model.
    task automatic model(input int d, input logic st, input logic ab,
                         input logic [3:0] cn, input int h, input int l);
        exp_t last;
        last = (d == 0) ? last_a : last_b;
        if (rst)              clear_q(d);
        else if (last.busy) begin
            if (ab) clear_q(d);
        end else if (st)      launch(d, int'(cn), h, l);
    endtask

    task automatic tick();
        exp_t e;
        model(0, start_a, abort_a, cnt_a, HA, LA);
        model(1, start_b, abort_b, cnt_b, HB, LB);
        @(posedge clk);
        #1;
        e = (qa.size() != 0) ? qa.pop_front() : exp_t'('0);
        check("a_pulse", 32'(pulse_a), 32'(e.pulse));
        check("a_busy",  32'(busy_a),  32'(e.busy));
        check("a_done",  32'(done_a),  32'(e.done));
        check("a_rem",   32'(rem_a),   32'(e.rem));
        last_a = e;
        e = (qb.size() != 0) ? qb.pop_front() : exp_t'('0);
        check("b_pulse", 32'(pulse_b), 32'(e.pulse));
        check("b_busy",  32'(busy_b),  32'(e.busy));
        check("b_done",  32'(done_b),  32'(e.done));
        check("b_rem",   32'(rem_b),   32'(e.rem));
        last_b = e;
        if (pulse_a === 1'b1 && prev_pa === 1'b0) npulse_a++;
        if (pulse_b === 1'b1 && prev_pb === 1'b0) npulse_b++;
        prev_pa = pulse_a;
        prev_pb = pulse_b;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; cnt_a = '0;
        start_b = 1'b0; abort_b = 1'b0; cnt_b = '0;
        ticks(3);

        // Start on the first edge after reset: A count 3, B count 15.
        rst = 1'b0;
        npulse_a = 0; npulse_b = '0;
        start_a = 1'b1; cnt_a = 4'd3;
        start_b = 1'b1; cnt_b = 4'd15;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        ticks(75);                       // B done at T+76
        check("a_npulse_3", 32'(npulse_a), 32'd3);
        check("b_npulse_15", 32'(npulse_b), 32'd15);
        ticks(2);

        // Empty burst.
        npulse_a = 0;
        start_a = 1'b1; cnt_a = 4'd0;
        tick();
        start_a = 1'b0;
        ticks(3);
        check("a_npulse_0", 32'(npulse_a), 32'd0);

        // Start during second pulse of a 5-pulse burst is ignored.
        npulse_a = 0;
        start_a = 1'b1; cnt_a = 4'd5;
        tick();
        start_a = 1'b0;
        ticks(2);
        start_a = 1'b1; cnt_a = 4'd9;
        tick();
        start_a = 1'b0;
        ticks(7);                        // through done at T+11
        check("a_npulse_5", 32'(npulse_a), 32'd5);
        // Accepted in the done cycle (FSM already idle).
        start_a = 1'b1; cnt_a = 4'd2;
        tick();
        start_a = 1'b0;
        ticks(5);

        // Abort (with a competing start) during third of 6 pulses.
        npulse_a = 0;
        start_a = 1'b1; cnt_a = 4'd6;
        tick();
        start_a = 1'b0;
        ticks(4);
        abort_a = 1'b1; start_a = 1'b1; cnt_a = 4'd9;
        tick();
        abort_a = 1'b0;
        start_a = 1'b1; cnt_a = 4'd1;
        tick();
        start_a = 1'b0;
        ticks(3);
        check("a_npulse_abort", 32'(npulse_a), 32'd4);

        // Abort together with start while idle: start proceeds.
        abort_a = 1'b1; start_a = 1'b1; cnt_a = 4'd2;
        tick();
        abort_a = 1'b0; start_a = 1'b0;
        ticks(5);

        // Reset mid-HIGH with start asserted in the same cycle.
        start_a = 1'b1; cnt_a = 4'd4;
        start_b = 1'b1; cnt_b = 4'd2;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        ticks(1);
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
        tick();
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        ticks(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
